// File: rtl/fp_unit_sp_pkg.sv
// fp_wire: shared types and constants for the single-precision FP unit.
// Holds the execute-stage request/response records, rounding-mode and
// compare-selector encodings, flag bit positions and a leading-zero counter.
package fp_wire;

  typedef struct packed {
    logic       fmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fcmp;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
  } fp_exe_out_type;

  typedef struct packed {
    fp_exe_in_type fp_exe_i;
  } fp_unit_in_type;

  typedef struct packed {
    fp_exe_out_type fp_exe_o;
  } fp_unit_out_type;

  // Rounding modes; 5-7 fall back to round-to-nearest-even.
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Compare predicates share the rm field.
  localparam logic [2:0] CMP_LE = 3'd0;
  localparam logic [2:0] CMP_LT = 3'd1;
  localparam logic [2:0] CMP_EQ = 3'd2;

  // Flag vector is {NV, DZ, OF, UF, NX}.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Count of leading zeros; a zero input is handled by callers separately.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_unit_sp_cvt.sv
// fp_cvt: int32 <-> single-precision conversions with IEEE rounding.
// Config macro FP_UNIT_RMM_EN: when defined, rm=4 rounds to nearest with ties
// away from zero; otherwise rm=4 behaves as round-to-nearest-even.
module fp_cvt
  import fp_wire::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  rm_i,
  input  logic        unsigned_i,
  output logic [31:0] i2fResult_o,
  output logic [4:0]  i2fFlags_o,
  output logic [31:0] f2iResult_o,
  output logic [4:0]  f2iFlags_o
);

  // Round-up decision shared by both conversion directions (sign-aware).
  function automatic logic roundInc(input logic sign, input logic lsb,
                                    input logic guard, input logic sticky,
                                    input logic [2:0] rm);
    logic inc;
    inc = guard & (sticky | lsb);
    case (rm)
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = sign & (guard | sticky);
      RM_RUP: inc = ~sign & (guard | sticky);
`ifdef FP_UNIT_RMM_EN
      RM_RMM: inc = guard;
`endif
      default: ;
    endcase
    return inc;
  endfunction

  logic        i2fNeg;
  logic [31:0] i2fMag;
  logic [4:0]  i2fLz;
  logic [31:0] i2fNorm;
  logic        i2fGuard;
  logic        i2fSticky;
  logic        i2fInc;
  logic [24:0] i2fSum;
  logic [7:0]  i2fExpM1;
  logic [30:0] i2fBody;

  // Integer to float: normalise the magnitude, round to 24 bits, then add the
  // significand onto (exponent-1) so the hidden bit and any rounding carry
  // bump the exponent field for free.
  always_comb begin
    i2fNeg     = ~unsigned_i & data_i[31];
    i2fMag     = i2fNeg ? (~data_i + 32'd1) : data_i;
    i2fLz      = lzc32(i2fMag);
    i2fNorm    = i2fMag << i2fLz;
    i2fGuard   = i2fNorm[7];
    i2fSticky  = |i2fNorm[6:0];
    i2fInc     = roundInc(i2fNeg, i2fNorm[8], i2fGuard, i2fSticky, rm_i);
    i2fSum     = {1'b0, i2fNorm[31:8]} + {24'd0, i2fInc};
    i2fExpM1   = 8'd157 - {3'd0, i2fLz};
    i2fBody    = {i2fExpM1, 23'd0} + {6'd0, i2fSum};
    i2fResult_o = '0;
    i2fFlags_o  = '0;
    if (i2fMag != 32'd0) begin
      i2fResult_o          = {i2fNeg, i2fBody};
      i2fFlags_o[FLAG_NX]  = i2fGuard | i2fSticky;
    end
  end

  logic        fSign;
  logic [7:0]  fExp;
  logic        fNan;
  logic [23:0] fSig;
  logic        fBig;
  logic [55:0] fWide;
  logic [31:0] fInt;
  logic        fGuard;
  logic        fSticky;
  logic        fInc;
  logic [32:0] fRounded;
  logic        fInexact;

  // Float to integer: place the significand in a 32.24 fixed-point window,
  // round the integer part, then saturate out-of-range and NaN inputs.
  always_comb begin
    fSign    = data_i[31];
    fExp     = data_i[30:23];
    fNan     = (&fExp) & (|data_i[22:0]);
    fSig     = {|fExp, data_i[22:0]};
    fBig     = 1'b0;
    fWide    = '0;
    fInt     = '0;
    fGuard   = 1'b0;
    fSticky  = 1'b0;
    if (fExp >= 8'd159) begin
      fBig = 1'b1;
    end else if (fExp >= 8'd126) begin
      fWide   = {32'd0, fSig} << (fExp - 8'd126);
      fInt    = fWide[55:24];
      fGuard  = fWide[23];
      fSticky = |fWide[22:0];
    end else begin
      fSticky = |data_i[30:0];
    end
    fInc       = roundInc(fSign, fInt[0], fGuard, fSticky, rm_i);
    fRounded   = {1'b0, fInt} + {32'd0, fInc};
    fInexact   = fGuard | fSticky;
    f2iResult_o = '0;
    f2iFlags_o  = '0;
    if (fNan) begin
      f2iResult_o         = unsigned_i ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      f2iFlags_o[FLAG_NV] = 1'b1;
    end else if (!unsigned_i) begin
      if (fSign) begin
        if (fBig || fRounded > 33'h0_8000_0000) begin
          f2iResult_o         = 32'h8000_0000;
          f2iFlags_o[FLAG_NV] = 1'b1;
        end else begin
          f2iResult_o         = ~fRounded[31:0] + 32'd1;
          f2iFlags_o[FLAG_NX] = fInexact;
        end
      end else if (fBig || fRounded > 33'h0_7FFF_FFFF) begin
        f2iResult_o         = 32'h7FFF_FFFF;
        f2iFlags_o[FLAG_NV] = 1'b1;
      end else begin
        f2iResult_o         = fRounded[31:0];
        f2iFlags_o[FLAG_NX] = fInexact;
      end
    end else begin
      if (fSign) begin
        if (fBig || fRounded != 33'd0) f2iFlags_o[FLAG_NV] = 1'b1;
        else                           f2iFlags_o[FLAG_NX] = fInexact;
      end else if (fBig || fRounded[32]) begin
        f2iResult_o         = 32'hFFFF_FFFF;
        f2iFlags_o[FLAG_NV] = 1'b1;
      end else begin
        f2iResult_o         = fRounded[31:0];
        f2iFlags_o[FLAG_NX] = fInexact;
      end
    end
  end

endmodule

// File: rtl/fp_unit_sp.sv
// fp_unit_sp: single-precision compare and int<->float conversion unit with a
// one-cycle registered result. Config macro FP_UNIT_RMM_EN enables
// ties-away rounding for rm=4 inside fp_cvt.
module fp_unit_sp
  import fp_wire::*;
(
  input  logic            clock,
  input  logic            reset,
  input  fp_unit_in_type  fp_unit_i,
  output fp_unit_out_type fp_unit_o
);

  fp_exe_in_type  exeIn;
  fp_exe_out_type out_d;
  fp_exe_out_type out_q;

  assign exeIn = fp_unit_i.fp_exe_i;

  logic        aNan;
  logic        bNan;
  logic        aSnan;
  logic        bSnan;
  logic        bothZero;
  logic        cmpEq;
  logic        cmpLt;
  logic [31:0] cmpResult;
  logic [4:0]  cmpFlags;

  // Sign-magnitude compare; +0 and -0 are equal, NaNs are unordered.
  always_comb begin
    aNan     = (&exeIn.data1[30:23]) & (|exeIn.data1[22:0]);
    bNan     = (&exeIn.data2[30:23]) & (|exeIn.data2[22:0]);
    aSnan    = aNan & ~exeIn.data1[22];
    bSnan    = bNan & ~exeIn.data2[22];
    bothZero = ~|{exeIn.data1[30:0], exeIn.data2[30:0]};
    cmpEq    = (exeIn.data1 == exeIn.data2) | bothZero;
    if (bothZero)
      cmpLt = 1'b0;
    else if (exeIn.data1[31] != exeIn.data2[31])
      cmpLt = exeIn.data1[31];
    else if (exeIn.data1[31])
      cmpLt = exeIn.data1[30:0] > exeIn.data2[30:0];
    else
      cmpLt = exeIn.data1[30:0] < exeIn.data2[30:0];
    cmpResult = '0;
    cmpFlags  = '0;
    case (exeIn.rm)
      CMP_LE: begin
        if (aNan | bNan) cmpFlags[FLAG_NV] = 1'b1;
        else             cmpResult[0] = cmpLt | cmpEq;
      end
      CMP_LT: begin
        if (aNan | bNan) cmpFlags[FLAG_NV] = 1'b1;
        else             cmpResult[0] = cmpLt;
      end
      CMP_EQ: begin
        if (aNan | bNan) cmpFlags[FLAG_NV] = aSnan | bSnan;
        else             cmpResult[0] = cmpEq;
      end
      default: ;
    endcase
  end

  logic [31:0] i2fResult;
  logic [4:0]  i2fFlags;
  logic [31:0] f2iResult;
  logic [4:0]  f2iFlags;

  fp_cvt u_cvt (
    .data_i      (exeIn.data1),
    .rm_i        (exeIn.rm),
    .unsigned_i  (exeIn.op.fcvt_op[0]),
    .i2fResult_o (i2fResult),
    .i2fFlags_o  (i2fFlags),
    .f2iResult_o (f2iResult),
    .f2iFlags_o  (f2iFlags)
  );

  // Arithmetic ops, data3, fmt and the upper fcvt_op bit have no effect here.
  logic unusedBits;
  assign unusedBits = ^{exeIn.data3, exeIn.fmt, exeIn.op.fmadd, exeIn.op.fadd,
                        exeIn.op.fsub, exeIn.op.fmul, exeIn.op.fdiv,
                        exeIn.op.fsqrt, exeIn.op.fcvt_op[1]};

  // Select the active operation's result; idle or unsupported ops give 0/0.
  always_comb begin
    out_d = '0;
    if (exeIn.enable) begin
      if (exeIn.op.fcmp) begin
        out_d.result = cmpResult;
        out_d.flags  = cmpFlags;
      end else if (exeIn.op.fcvt_i2f) begin
        out_d.result = i2fResult;
        out_d.flags  = i2fFlags;
      end else if (exeIn.op.fcvt_f2i) begin
        out_d.result = f2iResult;
        out_d.flags  = f2iFlags;
      end
    end
  end

  // Output register loads every cycle; reset discards any in-flight op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign fp_unit_o.fp_exe_o = out_q;

endmodule

// File: tb/tb_fp_unit_sp.sv
// tb_fp_unit_sp: scoreboard bench for fp_unit_sp using directed vectors.
// Honors FP_UNIT_RMM_EN for the expected rm=4 tie result.
module tb_fp_unit_sp;
  import fp_wire::*;

  logic            clock;
  logic            reset;
  fp_unit_in_type  unitIn;
  fp_unit_out_type unitOut;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          due;
    string       name;
  } sb_entry_t;

  sb_entry_t sbQueue[$];
  int checks     = 0;
  int failures   = 0;
  int cycleCount = 0;

  localparam int K_NONE = 0;
  localparam int K_CMP  = 1;
  localparam int K_I2F  = 2;
  localparam int K_F2I  = 3;

`ifdef FP_UNIT_RMM_EN
  localparam logic [31:0] RMM_TIE_EXP = 32'd3;
`else
  localparam logic [31:0] RMM_TIE_EXP = 32'd2;
`endif

  fp_unit_sp dut (
    .clock     (clock),
    .reset     (reset),
    .fp_unit_i (unitIn),
    .fp_unit_o (unitOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input logic [31:0] expRes, input logic [4:0] expFlg,
                             input string name);
    checks++;
    if (unitOut.fp_exe_o.result !== expRes || unitOut.fp_exe_o.flags !== expFlg) begin
      failures++;
      $display("[TB] FAIL %s: got result=%h flags=%h, expected result=%h flags=%h",
               name, unitOut.fp_exe_o.result, unitOut.fp_exe_o.flags, expRes, expFlg);
    end
  endtask

  task automatic applyStimulus(input string name, input int kind,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] rm, input logic unsignedOp,
                               input logic en, input logic [31:0] expRes,
                               input logic [4:0] expFlg);
    sb_entry_t e;
    @(negedge clock);
    unitIn                      = '0;
    unitIn.fp_exe_i.op          = init_fp_operation;
    unitIn.fp_exe_i.data1       = a;
    unitIn.fp_exe_i.data2       = b;
    unitIn.fp_exe_i.rm          = rm;
    unitIn.fp_exe_i.enable      = en;
    unitIn.fp_exe_i.op.fcvt_op  = {1'b0, unsignedOp};
    unitIn.fp_exe_i.op.fadd     = (kind == K_NONE);
    unitIn.fp_exe_i.op.fcmp     = (kind == K_CMP);
    unitIn.fp_exe_i.op.fcvt_i2f = (kind == K_I2F);
    unitIn.fp_exe_i.op.fcvt_f2i = (kind == K_F2I);
    e.res  = expRes;
    e.flg  = expFlg;
    e.due  = cycleCount + 1;
    e.name = name;
    sbQueue.push_back(e);
  endtask

  // Monitor: each queued expectation must appear exactly one cycle after issue.
  always @(negedge clock) begin
    while (sbQueue.size() > 0 && sbQueue[0].due <= cycleCount) begin
      sb_entry_t e;
      e = sbQueue.pop_front();
      if (e.due != cycleCount) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s: response not checked at cycle %0d, now cycle %0d",
                 e.name, e.due, cycleCount);
      end else begin
        checkOutput(e.res, e.flg, e.name);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    unitIn = '0;
    @(negedge clock);
    checkOutput(32'd0, 5'd0, "resetState");
    reset = 1'b0;

    // Compares
    applyStimulus("cmpLe",        K_CMP, 32'h3F800000, 32'h40000000, CMP_LE, 1'b0, 1'b1, 32'd1, 5'h00);
    applyStimulus("cmpEqZeros",   K_CMP, 32'h80000000, 32'h00000000, CMP_EQ, 1'b0, 1'b1, 32'd1, 5'h00);
    applyStimulus("cmpEqSnan",    K_CMP, 32'h7F800001, 32'h00000000, CMP_EQ, 1'b0, 1'b1, 32'd0, 5'h10);
    applyStimulus("cmpEqQnan",    K_CMP, 32'h7FC00000, 32'h00000000, CMP_EQ, 1'b0, 1'b1, 32'd0, 5'h00);
    applyStimulus("cmpLtQnan",    K_CMP, 32'h7FC00000, 32'h3F800000, CMP_LT, 1'b0, 1'b1, 32'd0, 5'h10);
    applyStimulus("cmpLtFalse",   K_CMP, 32'h40000000, 32'h3F800000, CMP_LT, 1'b0, 1'b1, 32'd0, 5'h00);
    applyStimulus("cmpLtNegPos",  K_CMP, 32'hBF800000, 32'h3F800000, CMP_LT, 1'b0, 1'b1, 32'd1, 5'h00);
    applyStimulus("cmpLtNegNeg",  K_CMP, 32'hC0000000, 32'hBF800000, CMP_LT, 1'b0, 1'b1, 32'd1, 5'h00);
    applyStimulus("cmpLeEqual",   K_CMP, 32'h3F800000, 32'h3F800000, CMP_LE, 1'b0, 1'b1, 32'd1, 5'h00);
    applyStimulus("cmpLtZeros",   K_CMP, 32'h80000000, 32'h00000000, CMP_LT, 1'b0, 1'b1, 32'd0, 5'h00);
    applyStimulus("cmpRm3",       K_CMP, 32'h3F800000, 32'h3F800000, 3'd3,   1'b0, 1'b1, 32'd0, 5'h00);

    // Integer to float
    applyStimulus("i2fOne",       K_I2F, 32'h00000001, 32'd0, RM_RNE, 1'b0, 1'b1, 32'h3F800000, 5'h00);
    applyStimulus("i2fMaxRne",    K_I2F, 32'h7FFFFFFF, 32'd0, RM_RNE, 1'b0, 1'b1, 32'h4F000000, 5'h01);
    applyStimulus("i2fMaxRtz",    K_I2F, 32'h7FFFFFFF, 32'd0, RM_RTZ, 1'b0, 1'b1, 32'h4EFFFFFF, 5'h01);
    applyStimulus("i2fMinInt",    K_I2F, 32'h80000000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'hCF000000, 5'h00);
    applyStimulus("i2fZero",      K_I2F, 32'h00000000, 32'd0, RM_RDN, 1'b0, 1'b1, 32'h00000000, 5'h00);
    applyStimulus("i2fNegOne",    K_I2F, 32'hFFFFFFFF, 32'd0, RM_RNE, 1'b0, 1'b1, 32'hBF800000, 5'h00);
    applyStimulus("i2fUMaxRne",   K_I2F, 32'hFFFFFFFF, 32'd0, RM_RNE, 1'b1, 1'b1, 32'h4F800000, 5'h01);
    applyStimulus("i2fUMaxRtz",   K_I2F, 32'hFFFFFFFF, 32'd0, RM_RTZ, 1'b1, 1'b1, 32'h4F7FFFFF, 5'h01);
    applyStimulus("i2fNegRdn",    K_I2F, 32'h80000001, 32'd0, RM_RDN, 1'b0, 1'b1, 32'hCF000000, 5'h01);
    applyStimulus("i2fNegRup",    K_I2F, 32'h80000001, 32'd0, RM_RUP, 1'b0, 1'b1, 32'hCEFFFFFF, 5'h01);

    // Float to signed integer
    applyStimulus("f2i1p5Rne",    K_F2I, 32'h3FC00000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'd2,         5'h01);
    applyStimulus("f2i1p5Rtz",    K_F2I, 32'h3FC00000, 32'd0, RM_RTZ, 1'b0, 1'b1, 32'd1,         5'h01);
    applyStimulus("f2iNeg1p5Rdn", K_F2I, 32'hBFC00000, 32'd0, RM_RDN, 1'b0, 1'b1, 32'hFFFFFFFE,  5'h01);
    applyStimulus("f2i2p5Rne",    K_F2I, 32'h40200000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'd2,         5'h01);
    applyStimulus("f2i2p5Rmm",    K_F2I, 32'h40200000, 32'd0, RM_RMM, 1'b0, 1'b1, RMM_TIE_EXP,   5'h01);
    applyStimulus("f2iOverflow",  K_F2I, 32'h4F000000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'h7FFFFFFF,  5'h10);
    applyStimulus("f2iMinExact",  K_F2I, 32'hCF000000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'h80000000,  5'h00);
    applyStimulus("f2iNegInf",    K_F2I, 32'hFF800000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'h80000000,  5'h10);
    applyStimulus("f2iQnanS",     K_F2I, 32'h7FC00000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'h7FFFFFFF,  5'h10);
    applyStimulus("f2iOneRup",    K_F2I, 32'h3F800000, 32'd0, RM_RUP, 1'b0, 1'b1, 32'd1,         5'h00);
    applyStimulus("f2i0p3Rup",    K_F2I, 32'h3E99999A, 32'd0, RM_RUP, 1'b0, 1'b1, 32'd1,         5'h01);

    // Float to unsigned integer
    applyStimulus("f2uNegOne",    K_F2I, 32'hBF800000, 32'd0, RM_RNE, 1'b1, 1'b1, 32'd0,         5'h10);
    applyStimulus("f2uNeg0p3",    K_F2I, 32'hBE99999A, 32'd0, RM_RNE, 1'b1, 1'b1, 32'd0,         5'h01);
    applyStimulus("f2uQnan",      K_F2I, 32'h7FC00000, 32'd0, RM_RNE, 1'b1, 1'b1, 32'hFFFFFFFF,  5'h10);
    applyStimulus("f2uPosInf",    K_F2I, 32'h7F800000, 32'd0, RM_RNE, 1'b1, 1'b1, 32'hFFFFFFFF,  5'h10);
    applyStimulus("f2uTooBig",    K_F2I, 32'h4F800000, 32'd0, RM_RNE, 1'b1, 1'b1, 32'hFFFFFFFF,  5'h10);
    applyStimulus("f2uLargest",   K_F2I, 32'h4F7FFFFF, 32'd0, RM_RNE, 1'b1, 1'b1, 32'hFFFFFF00,  5'h00);

    // Control: disabled and unsupported ops produce zero
    applyStimulus("enableLow",    K_CMP, 32'h3F800000, 32'h40000000, CMP_LE, 1'b0, 1'b0, 32'd0, 5'h00);
    applyStimulus("faddOnly",     K_NONE, 32'h3F800000, 32'h40000000, RM_RNE, 1'b0, 1'b1, 32'd0, 5'h00);

    // Asynchronous reset while an op is being held at the input
    applyStimulus("holdOp",       K_F2I, 32'h3FC00000, 32'd0, RM_RNE, 1'b0, 1'b1, 32'd2, 5'h01);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput(32'd2, 5'h01, "heldBeforeReset");
    #2 reset = 1'b1;
    #1 checkOutput(32'd0, 5'h00, "asyncResetClears");
    @(negedge clock);
    unitIn.fp_exe_i.enable = 1'b0;
    @(posedge clock); #1;
    checkOutput(32'd0, 5'h00, "resetHeld");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput(32'd0, 5'h00, "idleAfterReset");

    applyStimulus("cmpAfterReset", K_CMP, 32'h3F800000, 32'h40000000, CMP_LT, 1'b0, 1'b1, 32'd1, 5'h00);
    applyStimulus("idleTail",      K_CMP, 32'h3F800000, 32'h40000000, CMP_LT, 1'b0, 1'b0, 32'd0, 5'h00);

    for (int i = 0; i < 5 && sbQueue.size() > 0; i++) @(negedge clock);
    if (sbQueue.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboardDrain: %0d responses outstanding, expected 0", sbQueue.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
